// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the memory arbiter: arbiter FSM states, the grant owner
// encoding, and the arbitration pick function that resolves contention
// between the fetch and data requesters.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_D  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // Data normally wins contention, but if data owned the previous completed
   // grant then fetch gets this one, so neither side can starve the other.
   function automatic owner_t pick_owner(input logic   i_if_req,
                                         input logic   i_d_req,
                                         input owner_t i_last);
      owner_t w_pick;
      if (i_if_req && i_d_req) begin
         w_pick = (i_last == OWN_D) ? OWN_IF : OWN_D;
      end else if (i_d_req) begin
         w_pick = OWN_D;
      end else begin
         w_pick = OWN_IF;
      end
      return w_pick;
   endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// -----------------------------------------------------------------------------
// arb_timer
// Wait-cycle counter for an outstanding bus transaction.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   i_clear    clears the count (asserted on the grant edge)
//   i_enable   counts one wait cycle (granted and no bus_ack this cycle)
//   o_expired  this wait cycle is the TIMEOUT-th one; the transaction must be
//              terminated with an error on the coming edge
// -----------------------------------------------------------------------------
module arb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Flag the cycle whose increment would make the count reach TIMEOUT, so
   // the error response is registered on the same edge the count gets there.
   assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-master (instruction fetch, load/store) to one-slave bus arbiter with
// alternating fairness under contention and a bus_ack timeout.
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch request and address
//   if_rdata/if_ack/if_err        fetch read data, completion pulse, timeout
//   d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request
//   d_rdata/d_ack/d_err           load data, completion pulse, timeout
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb  downstream request (held
//                                 stable for the whole grant)
//   bus_rdata/bus_ack             downstream read data and completion
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                d_err,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t        r_state;
   arb_state_t        w_state_next;
   owner_t            r_last;
   owner_t            w_pick;
   owner_t            w_owner;

   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;
   logic [STRB_W-1:0] r_bus_wstrb;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_ack;
   logic              r_d_ack;
   logic              r_if_err;
   logic              r_d_err;

   logic              w_in_gnt;
   logic              w_if_req;
   logic              w_d_req;
   logic              w_grant;
   logic              w_done;
   logic              w_timeout;
   logic              w_tmr_en;
   logic              w_expired;

   assign w_in_gnt = (r_state == GNT_IF) || (r_state == GNT_D);
   assign w_owner  = (r_state == GNT_D) ? OWN_D : OWN_IF;

   // A requester is still holding req during its own ack cycle; masking it
   // there means only a req still high on the following cycle is a new one.
   assign w_if_req = if_req & ~r_if_ack;
   assign w_d_req  = d_req  & ~r_d_ack;
   assign w_pick   = pick_owner(w_if_req, w_d_req, r_last);

   assign w_tmr_en = w_in_gnt && !bus_ack;

   arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_grant),
      .i_enable  (w_tmr_en),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_if_req || w_d_req) begin
               w_grant      = 1'b1;
               w_state_next = (w_pick == OWN_D) ? GNT_D : GNT_IF;
            end
         end
         GNT_IF, GNT_D: begin
            // bus_ack takes priority over an expiry in the same cycle.
            if (bus_ack) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end else if (w_expired) begin
               w_timeout    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_last  <= OWN_IF;
      end else begin
         r_state <= w_state_next;
         if (w_done || w_timeout) begin
            r_last <= w_owner;
         end
      end
   end

   // Downstream request fields are captured once at grant and then ignore the
   // requester inputs until the transaction ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_wstrb <= '0;
      end else if (w_grant) begin
         if (w_pick == OWN_D) begin
            r_bus_we    <= d_we;
            r_bus_addr  <= d_addr;
            r_bus_wdata <= d_wdata;
            r_bus_wstrb <= d_wstrb;
         end else begin
            r_bus_we    <= 1'b0;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
         end
      end
   end

   // Completion responses: single-cycle ack/err pulses, rdata held until the
   // same owner's next completion (zero after a timeout).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_ack   <= 1'b0;
         r_d_ack    <= 1'b0;
         r_if_err   <= 1'b0;
         r_d_err    <= 1'b0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         r_if_err <= 1'b0;
         r_d_err  <= 1'b0;
         if (w_done || w_timeout) begin
            if (w_owner == OWN_D) begin
               r_d_ack   <= 1'b1;
               r_d_err   <= w_timeout;
               r_d_rdata <= w_timeout ? '0 : bus_rdata;
            end else begin
               r_if_ack   <= 1'b1;
               r_if_err   <= w_timeout;
               r_if_rdata <= w_timeout ? '0 : bus_rdata;
            end
         end
      end
   end

   assign bus_req   = w_in_gnt;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_wstrb = r_bus_wstrb;
   assign if_rdata  = r_if_rdata;
   assign if_ack    = r_if_ack;
   assign if_err    = r_if_err;
   assign d_rdata   = r_d_rdata;
   assign d_ack     = r_d_ack;
   assign d_err     = r_d_err;

endmodule
